pwm_modulator_mc: RTL and testbench



---
 rtl/pwm_modulator_mc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pwm_modulator_mc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_modulator_mc.sv
// pwm_modulator_mc: multi-channel PWM modulator. All channels share one
// prescaled period counter (edge- or center-aligned). Duty, period, prescaler
// and mode are double-buffered: writes land in pending registers and move to
// the active set only at a period boundary or when the block is enabled.
//
// Optional feature macro: PWM_MODULATOR_MC_DEADTIME_EN
//   adds complementary outputs pwm_out_n and a shadowed deadtime register
//   at address NUM_CH+3.
//
// state   | meaning
// ST_IDLE | counter stopped, outputs held at the idle polarity
// ST_RUN  | counting; outputs follow cnt against the active duty

module pwm_modulator_mc #(
  parameter int                NUM_CH    = 4,
  parameter int                CNT_WIDTH = 8,
  parameter logic [NUM_CH-1:0] INV_MASK  = {NUM_CH{1'b0}},
  parameter int                ADDR_W    = $clog2(NUM_CH + 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [NUM_CH-1:0]    pwm_out,
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
  output logic [NUM_CH-1:0]    pwm_out_n,
`endif
  output logic                 period_strobe,
  output logic                 busy
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_CH + 2);
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
  localparam logic [ADDR_W-1:0] A_DEAD   = ADDR_W'(NUM_CH + 3);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // pending (shadow) registers
  cnt_t duty_pend [NUM_CH];
  cnt_t p_pend;
  cnt_t s_pend;
  logic mode_pend;

  // active registers
  cnt_t duty_act [NUM_CH];
  cnt_t p_act;
  cnt_t s_act;
  logic mode_act;

`ifdef PWM_MODULATOR_MC_DEADTIME_EN
  cnt_t d_pend;
  cnt_t d_act;
`endif

  cnt_t cnt;
  cnt_t cnt_nxt;
  cnt_t presc;
  logic dir_up;
  logic dir_nxt;
  logic tick;
  logic boundary;

  logic ctrl_wr;
  logic start;
  logic stop;
  logic running;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] pwm_q;

  assign ctrl_wr = wr_en && (wr_addr == A_CTRL);

  // register port writes into the pending set; unmapped addresses fall through
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) duty_pend[i] <= '0;
      p_pend    <= '0;
      s_pend    <= '0;
      mode_pend <= 1'b0;
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
      d_pend    <= '0;
`endif
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == ADDR_W'(i)) duty_pend[i] <= wr_data;
      end
      if (wr_addr == A_PERIOD) p_pend <= wr_data;
      if (wr_addr == A_PRESC)  s_pend <= wr_data;
      if (wr_addr == A_CTRL)   mode_pend <= wr_data[1];
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
      if (wr_addr == A_DEAD)   d_pend <= wr_data;
`endif
    end
  end

  // run/idle state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state plus start/stop decode from ctrl.en writes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    running   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_wr && wr_data[0]) begin
          start     = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (ctrl_wr && !wr_data[0]) begin
          stop      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = running;

  // prescaler is a down-counter reloaded with S; terminal count gives the tick
  assign tick = running && (presc == '0);

  // counter step for one tick; center mode with P<=1 never turns around
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir_up;
    if (!mode_act) begin
      cnt_nxt = (cnt == p_act) ? '0 : cnt + cnt_t'(1);
    end else if (dir_up) begin
      if (cnt != p_act) begin
        cnt_nxt = cnt + cnt_t'(1);
      end else if (p_act > cnt_t'(1)) begin
        cnt_nxt = cnt - cnt_t'(1);
        dir_nxt = 1'b0;
      end else begin
        cnt_nxt = '0;
      end
    end else begin
      cnt_nxt = cnt - cnt_t'(1);
      if (cnt == cnt_t'(1)) dir_nxt = 1'b1;
    end
  end

  assign boundary      = tick && (cnt_nxt == '0) && ((cnt != '0) || (p_act == '0));
  assign period_strobe = boundary;

  // shared counter, prescaler and active-set loading at start or boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      presc    <= '0;
      dir_up   <= 1'b1;
      p_act    <= '0;
      s_act    <= '0;
      mode_act <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
      d_act    <= '0;
`endif
    end else if (start) begin
      cnt      <= '0;
      presc    <= s_pend;
      dir_up   <= 1'b1;
      p_act    <= p_pend;
      s_act    <= s_pend;
      mode_act <= wr_data[1];
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_pend[i];
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
      d_act    <= d_pend;
`endif
    end else if (stop) begin
      cnt    <= '0;
      presc  <= '0;
      dir_up <= 1'b1;
    end else if (tick) begin
      cnt <= cnt_nxt;
      if (boundary) begin
        dir_up   <= 1'b1;
        presc    <= s_pend;
        p_act    <= p_pend;
        s_act    <= s_pend;
        mode_act <= mode_pend;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_pend[i];
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
        d_act    <= d_pend;
`endif
      end else begin
        dir_up <= dir_nxt;
        presc  <= s_act;
      end
    end else if (running) begin
      presc <= presc - cnt_t'(1);
    end
  end

  // per-channel compare of the shared count against the active duty
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) raw[i] = running && (cnt < duty_act[i]);
  end

`ifdef PWM_MODULATOR_MC_DEADTIME_EN
  cnt_t              dt_tmr [NUM_CH];
  cnt_t              dt_nxt [NUM_CH];
  logic [NUM_CH-1:0] raw_q;
  logic [NUM_CH-1:0] pwm_n_q;

  // deadtime timers restart on every raw edge and count down to zero
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dt_nxt[i] = '0;
      if (raw[i] != raw_q[i])    dt_nxt[i] = d_act;
      else if (dt_tmr[i] != '0) dt_nxt[i] = dt_tmr[i] - cnt_t'(1);
    end
  end

  // complementary outputs: a side turns on only once its timer has expired
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      raw_q   <= '0;
      pwm_q   <= INV_MASK;
      pwm_n_q <= INV_MASK;
      for (int i = 0; i < NUM_CH; i++) dt_tmr[i] <= '0;
    end else begin
      raw_q <= raw;
      for (int i = 0; i < NUM_CH; i++) begin
        dt_tmr[i]  <= dt_nxt[i];
        pwm_q[i]   <= (raw[i] && (dt_nxt[i] == '0)) ^ INV_MASK[i];
        pwm_n_q[i] <= (running && !raw[i] && (dt_nxt[i] == '0)) ^ INV_MASK[i];
      end
    end
  end

  assign pwm_out_n = pwm_n_q;
`else
  // registered outputs; a disable forces the idle level on the same edge
  always_ff @(posedge clk) begin
    if (rst || stop) pwm_q <= INV_MASK;
    else             pwm_q <= raw ^ INV_MASK;
  end
`endif

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_modulator_mc.sv
// Bench for pwm_modulator_mc: directed scenarios followed by random register
// traffic, compared every cycle against a period/phase reference model.
// Define PWM_MODULATOR_MC_DEADTIME_EN to also exercise the deadtime outputs.

module tb_pwm_modulator_mc;

  localparam int                NUM_CH    = 4;
  localparam int                CNT_WIDTH = 8;
  localparam int                ADDR_W    = $clog2(NUM_CH + 4);
  localparam logic [NUM_CH-1:0] INV_MASK  = 4'b0001;
  localparam int                A_PER     = NUM_CH;
  localparam int                A_PRE     = NUM_CH + 1;
  localparam int                A_CTL     = NUM_CH + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic [ADDR_W-1:0]    wr_addr = '0;
  logic [CNT_WIDTH-1:0] wr_data = '0;
  logic [NUM_CH-1:0]    pwm_out;
  logic                 period_strobe;
  logic                 busy;
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
  logic [NUM_CH-1:0]    pwm_out_n;
`endif

  always #5 clk = ~clk;

  pwm_modulator_mc #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .INV_MASK(INV_MASK), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .pwm_out(pwm_out),
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
    .pwm_out_n(pwm_out_n),
`endif
    .period_strobe(period_strobe),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: period position k in ticks, prescale position pc
  int                m_duty_p [NUM_CH];
  int                m_duty_a [NUM_CH];
  int                m_p_p, m_p_a, m_s_p, m_s_a;
  bit                m_mode_p, m_mode_a, m_busy;
  int                m_k, m_pc;
  logic [NUM_CH-1:0] m_pwm;
  bit                m_strobe;
  bit                dt_phase = 1'b0;

  function automatic int period_len(input int p, input bit mode);
    if (!mode) return p + 1;
    if (p == 0) return 1;
    return 2 * p;
  endfunction

  function automatic int cnt_of(input int k, input int p, input bit mode);
    if (mode && k > p) return 2 * p - k;
    return k;
  endfunction

  task automatic load_actives();
    for (int i = 0; i < NUM_CH; i++) m_duty_a[i] = m_duty_p[i];
    m_p_a    = m_p_p;
    m_s_a    = m_s_p;
    m_mode_a = m_mode_p;
  endtask

  task automatic model_clock(input bit r, input bit we, input int addr, input int data);
    int cnt;
    bit tick, bnd, ena, dis;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin m_duty_p[i] = 0; m_duty_a[i] = 0; end
      m_p_p = 0; m_p_a = 0; m_s_p = 0; m_s_a = 0;
      m_mode_p = 0; m_mode_a = 0; m_busy = 0; m_k = 0; m_pc = 0;
      m_pwm = INV_MASK; m_strobe = 0;
      return;
    end
    cnt  = cnt_of(m_k, m_p_a, m_mode_a);
    tick = m_busy && (m_pc == m_s_a);
    bnd  = tick && (m_k == period_len(m_p_a, m_mode_a) - 1);
    ena  = we && addr == A_CTL && data[0] && !m_busy;
    dis  = we && addr == A_CTL && !data[0] && m_busy;
    for (int i = 0; i < NUM_CH; i++)
      m_pwm[i] = (!dis && m_busy && cnt < m_duty_a[i]) ^ INV_MASK[i];
    if (ena) begin
      load_actives();
      m_mode_a = data[1];
      m_busy = 1; m_k = 0; m_pc = 0;
    end else if (dis) begin
      m_busy = 0; m_k = 0; m_pc = 0;
    end else if (m_busy) begin
      if (tick) begin
        m_pc = 0;
        m_k  = (m_k + 1) % period_len(m_p_a, m_mode_a);
        if (bnd) load_actives();
      end else begin
        m_pc++;
      end
    end
    if (we) begin
      if (addr < NUM_CH)      m_duty_p[addr] = data;
      else if (addr == A_PER) m_p_p = data;
      else if (addr == A_PRE) m_s_p = data;
      else if (addr == A_CTL) m_mode_p = data[1];
    end
    m_strobe = m_busy && (m_pc == m_s_a) && (m_k == period_len(m_p_a, m_mode_a) - 1);
  endtask

  task automatic step(input bit r, input bit we, input int addr, input int data);
    rst     = r;
    wr_en   = we;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = data[CNT_WIDTH-1:0];
    @(posedge clk);
    model_clock(r, we, addr, data);
    #1;
    if (!dt_phase) check_val("pwm_out", {28'd0, pwm_out}, {28'd0, m_pwm});
    check_val("period_strobe", {31'd0, period_strobe}, {31'd0, m_strobe});
    check_val("busy", {31'd0, busy}, {31'd0, m_busy});
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  // one window: steps until a strobe is seen, counting active output cycles
  int w_len, w_hin, w_ovl;
  int w_hi [NUM_CH];
  bit w_ok;

  task automatic measure(input bit we, input int addr, input int data);
    w_len = 0; w_hin = 0; w_ovl = 0; w_ok = 0;
    foreach (w_hi[i]) w_hi[i] = 0;
    while (!w_ok && w_len < 400) begin
      if (w_len == 0) step(0, we, addr, data);
      else            step(0, 0, 0, 0);
      w_len++;
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i] ^ INV_MASK[i]) w_hi[i]++;
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
      if (pwm_out_n[0] ^ INV_MASK[0]) w_hin++;
      if ((pwm_out_n[0] ^ INV_MASK[0]) && (pwm_out[0] ^ INV_MASK[0])) w_ovl++;
`endif
      if (period_strobe) w_ok = 1;
    end
    check_val("strobe_seen", {31'd0, w_ok}, 32'd1);
  endtask

  initial begin
    // reset
    repeat (3) step(1, 0, 0, 0);
    check_val("reset_pwm", {28'd0, pwm_out}, {28'd0, INV_MASK});
    check_val("reset_busy", {31'd0, busy}, 32'd0);

    // edge mode, P=9, S=0, boundary duties
    step(0, 1, A_PER, 9);
    step(0, 1, A_PRE, 0);
    step(0, 1, 0, 3);
    step(0, 1, 1, 0);
    step(0, 1, 2, 10);
    step(0, 1, 3, 255);
    measure(1, A_CTL, 1);
    check_val("t1_first_len", w_len, 10);
    measure(0, 0, 0);
    check_val("t1_len", w_len, 10);
    check_val("t1_hi0", w_hi[0], 3);
    check_val("t3_hi1_duty0", w_hi[1], 0);
    check_val("t3_hi2_duty_p1", w_hi[2], 10);
    check_val("t3_hi3_duty255", w_hi[3], 10);

    // duty write in the strobe cycle, then mid-period
    measure(1, 0, 7);
    check_val("t2_strobe_write_old", w_hi[0], 3);
    measure(0, 0, 0);
    check_val("t2_strobe_write_new", w_hi[0], 7);
    repeat (4) step(0, 0, 0, 0);
    measure(1, 0, 5);
    measure(0, 0, 0);
    check_val("t2_mid_write_new", w_hi[0], 5);

    // disable mid-period, idle level, re-enable restarts from 0
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, A_CTL, 0);
    check_val("t5_dis_busy", {31'd0, busy}, 32'd0);
    check_val("t3_idle_pwm", {28'd0, pwm_out}, {28'd0, INV_MASK});
    repeat (5) step(0, 0, 0, 0);
    check_val("t5_idle_pwm_hold", {28'd0, pwm_out}, {28'd0, INV_MASK});
    measure(1, A_CTL, 1);
    check_val("t5_reen_len", w_len, 10);

    // center mode, P=4, S=1
    step(0, 1, A_CTL, 0);
    step(0, 1, 0, 2);
    step(0, 1, A_PER, 4);
    step(0, 1, A_PRE, 1);
    step(0, 1, A_CTL, 2);
    measure(1, A_CTL, 3);
    check_val("t4_first_len", w_len, 16);
    measure(0, 0, 0);
    check_val("t4_len", w_len, 16);
    check_val("t4_hi0", w_hi[0], 6);
    check_val("t4_hi2_duty_gt_p", w_hi[2], 16);

    // random register traffic
    step(1, 0, 0, 0);
    step(0, 1, A_PER, 5);
    step(0, 1, A_CTL, 1);
    for (int c = 0; c < 4000; c++) begin
      int a, d;
      bit we, r;
      r  = ($urandom_range(0, 999) == 0);
      we = ($urandom_range(0, 3) == 0);
`ifdef PWM_MODULATOR_MC_DEADTIME_EN
      a  = $urandom_range(0, NUM_CH + 2);
`else
      a  = $urandom_range(0, NUM_CH + 3);
`endif
      if (a < NUM_CH)      d = $urandom_range(0, 15);
      else if (a == A_PER) d = $urandom_range(0, 12);
      else if (a == A_PRE) d = $urandom_range(0, 3);
      else if (a == A_CTL) begin
        d = (($urandom_range(0, 3) == 0) ? 0 : 1) | (int'($urandom_range(0, 1)) << 1);
        if ($urandom_range(0, 3) != 0) we = 0;
      end else d = $urandom_range(0, 255);
      step(r, we, a, d);
    end

`ifdef PWM_MODULATOR_MC_DEADTIME_EN
    // deadtime: P=19, duty0=10, D=2
    step(1, 0, 0, 0);
    dt_phase = 1'b1;
    step(0, 1, A_PER, 19);
    step(0, 1, 0, 10);
    step(0, 1, NUM_CH + 3, 2);
    measure(1, A_CTL, 1);
    measure(0, 0, 0);
    check_val("dt_len", w_len, 20);
    check_val("dt_hi_p", w_hi[0], 8);
    check_val("dt_hi_n", w_hin, 8);
    check_val("dt_overlap", w_ovl, 0);
    measure(1, 0, 1);
    measure(0, 0, 0);
    measure(0, 0, 0);
    check_val("dt_short_hi_p", w_hi[0], 0);
    check_val("dt_short_hi_n", w_hin, 17);
    step(0, 1, A_CTL, 0);
    check_val("dt_idle_p", {28'd0, pwm_out}, {28'd0, INV_MASK});
    check_val("dt_idle_n", {28'd0, pwm_out_n}, {28'd0, INV_MASK});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
